// File: rtl/sync_fifo_flags_pkg.sv
//------------------------------------------------------------------------------
// sync_fifo_flags_pkg
// Shared types, pointer sizing and parameter legality helpers for sync_fifo_flags.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package sync_fifo_flags_pkg;

  typedef enum logic {
    RD_STANDARD = 1'b0,
    RD_FWFT     = 1'b1
  } rd_mode_e;

  function automatic int ptr_bits_f(input int depth);
    return $clog2(depth);
  endfunction

  function automatic bit is_pow2_f(input int value);
    return (value >= 2) && ((value & (value - 1)) == 0);
  endfunction

  // AE_THRESH < AF_THRESH <= DEPTH, with both thresholds inside the count range.
  function automatic bit params_ok_f(input int depth, input int af_thresh, input int ae_thresh);
    return is_pow2_f(depth) &&
           (af_thresh >= 1) && (af_thresh <= depth) &&
           (ae_thresh >= 0) && (ae_thresh <= depth - 1) &&
           (ae_thresh < af_thresh);
  endfunction

endpackage

`default_nettype wire

// File: rtl/sync_fifo_flags_if.sv
//------------------------------------------------------------------------------
// sync_fifo_flags_if
// Producer/consumer handshake, status and debug bundle of the single-clock FIFO.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface sync_fifo_flags_if #(
  parameter int DATA_WIDTH = 6,
  parameter int PTR_W      = 4
);

  logic                  wr_en;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  rd_en;
  logic                  clr_err;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  FULL;
  logic                  EMPTY;
  logic                  ALMOST_FULL;
  logic                  ALMOST_EMPTY;
  logic [PTR_W-1:0]      count;
  logic                  overflow;
  logic                  underflow;
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;

  modport master (
    output wr_en, data_in, rd_en, clr_err,
    input  data_out, FULL, EMPTY, ALMOST_FULL, ALMOST_EMPTY,
    input  count, overflow, underflow, wr_ptr, rd_ptr
  );

  modport slave (
    input  wr_en, data_in, rd_en, clr_err,
    output data_out, FULL, EMPTY, ALMOST_FULL, ALMOST_EMPTY,
    output count, overflow, underflow, wr_ptr, rd_ptr
  );

endinterface

`default_nettype wire

// File: rtl/sync_fifo_flags_flag_gen.sv
//------------------------------------------------------------------------------
// fifo_flag_gen
// Decodes occupancy and status flags from the registered binary pointers.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module fifo_flag_gen #(
  parameter int PTR_W     = 4,
  parameter int AF_THRESH = 6,
  parameter int AE_THRESH = 2
) (
  input  wire logic [PTR_W-1:0] wr_ptr,
  input  wire logic [PTR_W-1:0] rd_ptr,
  output logic      [PTR_W-1:0] count,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty
);

  localparam logic [PTR_W-1:0] c_AF = PTR_W'(AF_THRESH);
  localparam logic [PTR_W-1:0] c_AE = PTR_W'(AE_THRESH);

  logic [PTR_W-1:0] w_count;

  // Modular subtraction gives the right occupancy across pointer wrap.
  assign w_count      = wr_ptr - rd_ptr;
  assign count        = w_count;
  assign empty        = (wr_ptr == rd_ptr);
  assign full         = (wr_ptr[PTR_W-1] != rd_ptr[PTR_W-1]) &&
                        (wr_ptr[PTR_W-2:0] == rd_ptr[PTR_W-2:0]);
  assign almost_full  = (w_count >= c_AF);
  assign almost_empty = (w_count <= c_AE);

endmodule

`default_nettype wire

// File: rtl/sync_fifo_flags.sv
//------------------------------------------------------------------------------
// sync_fifo_flags
// Single-clock FIFO with occupancy, almost flags, sticky errors and optional FWFT.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module sync_fifo_flags
  import sync_fifo_flags_pkg::*;
#(
  parameter int DEPTH      = 8,
  parameter int DATA_WIDTH = 6,
  parameter int FWFT       = 0,
  parameter int AF_THRESH  = 6,
  parameter int AE_THRESH  = 2
) (
  input  wire logic         clk,
  input  wire logic         rst_n,
  sync_fifo_flags_if.slave  bus
);

  localparam int       c_PTR_BITS = ptr_bits_f(DEPTH);
  localparam int       c_PTR_W    = c_PTR_BITS + 1;
  localparam rd_mode_e c_RD_MODE  = (FWFT != 0) ? RD_FWFT : RD_STANDARD;

  if (!params_ok_f(DEPTH, AF_THRESH, AE_THRESH)) begin : g_param_err
    $error("sync_fifo_flags: illegal DEPTH/AF_THRESH/AE_THRESH combination");
  end

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [c_PTR_W-1:0]    r_wr_ptr;
  logic [c_PTR_W-1:0]    r_rd_ptr;
  logic                  r_overflow;
  logic                  r_underflow;

  logic [c_PTR_W-1:0]    w_count;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_almost_full;
  logic                  w_almost_empty;
  logic                  w_wr_accept;
  logic                  w_rd_accept;
  logic [c_PTR_BITS-1:0] w_wr_idx;
  logic [c_PTR_BITS-1:0] w_rd_idx;

  fifo_flag_gen #(
    .PTR_W     (c_PTR_W),
    .AF_THRESH (AF_THRESH),
    .AE_THRESH (AE_THRESH)
  ) u_flag_gen (
    .wr_ptr       (r_wr_ptr),
    .rd_ptr       (r_rd_ptr),
    .count        (w_count),
    .full         (w_full),
    .empty        (w_empty),
    .almost_full  (w_almost_full),
    .almost_empty (w_almost_empty)
  );

  assign w_wr_accept = bus.wr_en && !w_full;
  assign w_rd_accept = bus.rd_en && !w_empty;
  assign w_wr_idx    = r_wr_ptr[c_PTR_BITS-1:0];
  assign w_rd_idx    = r_rd_ptr[c_PTR_BITS-1:0];

  always_ff @(posedge clk) begin
    if (w_wr_accept) begin
      r_mem[w_wr_idx] <= bus.data_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr_accept) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_rd_accept) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
    end
  end

  // Setting an error wins over a same-cycle clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (bus.wr_en && w_full) begin
        r_overflow <= 1'b1;
      end else if (bus.clr_err) begin
        r_overflow <= 1'b0;
      end
      if (bus.rd_en && w_empty) begin
        r_underflow <= 1'b1;
      end else if (bus.clr_err) begin
        r_underflow <= 1'b0;
      end
    end
  end

  if (c_RD_MODE == RD_FWFT) begin : g_fwft
    assign bus.data_out = w_empty ? '0 : r_mem[w_rd_idx];
  end else begin : g_std
    logic [DATA_WIDTH-1:0] r_data_out;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_data_out <= '0;
      end else if (w_rd_accept) begin
        r_data_out <= r_mem[w_rd_idx];
      end
    end

    assign bus.data_out = r_data_out;
  end

  assign bus.FULL         = w_full;
  assign bus.EMPTY        = w_empty;
  assign bus.ALMOST_FULL  = w_almost_full;
  assign bus.ALMOST_EMPTY = w_almost_empty;
  assign bus.count        = w_count;
  assign bus.overflow     = r_overflow;
  assign bus.underflow    = r_underflow;
  assign bus.wr_ptr       = r_wr_ptr;
  assign bus.rd_ptr       = r_rd_ptr;

endmodule

`default_nettype wire

// File: tb/tb_sync_fifo_flags.sv
//------------------------------------------------------------------------------
// tb_sync_fifo_flags
// Standard and FWFT FIFOs driven side by side, checked against a queue model.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_sync_fifo_flags;

  localparam int DEPTH = 8;
  localparam int DW    = 6;
  localparam int PW    = 4;
  localparam int AF    = 6;
  localparam int AE    = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wr_en = 1'b0;
  logic          rd_en = 1'b0;
  logic          clr_err = 1'b0;
  logic [DW-1:0] data_in = '0;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  logic [DW-1:0] q[$];
  logic [DW-1:0] exp_dout;
  bit            exp_ovf;
  bit            exp_udf;
  int            n_wr;
  int            n_rd;

  always #5 clk = ~clk;

  sync_fifo_flags_if #(.DATA_WIDTH(DW), .PTR_W(PW)) bus_std ();
  sync_fifo_flags_if #(.DATA_WIDTH(DW), .PTR_W(PW)) bus_ft ();

  assign bus_std.wr_en   = wr_en;
  assign bus_std.rd_en   = rd_en;
  assign bus_std.clr_err = clr_err;
  assign bus_std.data_in = data_in;
  assign bus_ft.wr_en    = wr_en;
  assign bus_ft.rd_en    = rd_en;
  assign bus_ft.clr_err  = clr_err;
  assign bus_ft.data_in  = data_in;

  sync_fifo_flags #(.DEPTH(DEPTH), .DATA_WIDTH(DW), .FWFT(0), .AF_THRESH(AF), .AE_THRESH(AE))
    u_dut_std (.clk(clk), .rst_n(rst_n), .bus(bus_std));

  sync_fifo_flags #(.DEPTH(DEPTH), .DATA_WIDTH(DW), .FWFT(1), .AF_THRESH(AF), .AE_THRESH(AE))
    u_dut_ft (.clk(clk), .rst_n(rst_n), .bus(bus_ft));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    exp_dout = '0;
    exp_ovf  = 1'b0;
    exp_udf  = 1'b0;
    n_wr     = 0;
    n_rd     = 0;
  endtask

  task automatic check_all();
    int sz;
    sz = q.size();
    check("count",        32'(bus_std.count),        32'(sz));
    check("FULL",         32'(bus_std.FULL),         32'(sz == DEPTH));
    check("EMPTY",        32'(bus_std.EMPTY),        32'(sz == 0));
    check("ALMOST_FULL",  32'(bus_std.ALMOST_FULL),  32'(sz >= AF));
    check("ALMOST_EMPTY", 32'(bus_std.ALMOST_EMPTY), 32'(sz <= AE));
    check("overflow",     32'(bus_std.overflow),     32'(exp_ovf));
    check("underflow",    32'(bus_std.underflow),    32'(exp_udf));
    check("wr_ptr",       32'(bus_std.wr_ptr),       32'(n_wr % (2 * DEPTH)));
    check("rd_ptr",       32'(bus_std.rd_ptr),       32'(n_rd % (2 * DEPTH)));
    check("data_out_std", 32'(bus_std.data_out),     32'(exp_dout));
    check("count_ft",     32'(bus_ft.count),         32'(sz));
    check("overflow_ft",  32'(bus_ft.overflow),      32'(exp_ovf));
    check("underflow_ft", 32'(bus_ft.underflow),     32'(exp_udf));
    check("data_out_ft",  32'(bus_ft.data_out),      (sz == 0) ? 32'd0 : 32'(q[0]));
  endtask

  // One clock: drive at negedge, advance the model at posedge, compare just after.
  task automatic step(input bit wr, input logic [DW-1:0] din, input bit rd, input bit clr);
    bit was_full;
    bit was_empty;
    @(negedge clk);
    wr_en   = wr;
    data_in = din;
    rd_en   = rd;
    clr_err = clr;
    @(posedge clk);
    was_full  = (q.size() == DEPTH);
    was_empty = (q.size() == 0);
    if (wr && was_full) exp_ovf = 1'b1;
    else if (clr)       exp_ovf = 1'b0;
    if (rd && was_empty) exp_udf = 1'b1;
    else if (clr)        exp_udf = 1'b0;
    if (rd && !was_empty) begin
      exp_dout = q.pop_front();
      n_rd++;
    end
    if (wr && !was_full) begin
      q.push_back(din);
      n_wr++;
    end
    #1;
    check_all();
  endtask

  task automatic async_reset();
    @(negedge clk);
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    clr_err = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int phase_wr;
    int phase_rd;
    model_reset();
    #1;
    check_all();
    @(negedge clk);
    rst_n = 1'b1;

    // Fill with 1..8, then overflow and clear behaviour
    for (int i = 1; i <= DEPTH; i++) step(1'b1, DW'(i), 1'b0, 1'b0);
    step(1'b1, 6'h3F, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b1);
    step(1'b1, 6'h3F, 1'b0, 1'b1);
    step(1'b0, '0, 1'b0, 1'b1);

    // Drain with one extra read to trigger underflow
    for (int i = 0; i <= DEPTH; i++) step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b0, 1'b1);

    // Wrap-around at constant occupancy of 3
    for (int i = 0; i < 3; i++) step(1'b1, DW'($urandom), 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) step(1'b1, DW'($urandom), 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, 1'b0);

    // Simultaneous ops at empty then at full
    step(1'b1, 6'h15, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b1);
    for (int i = 0; i < DEPTH; i++) step(1'b1, DW'($urandom), 1'b0, 1'b0);
    step(1'b1, 6'h2B, 1'b1, 1'b0);

    // Reset mid-stream at count 5, then FWFT visibility of a single word
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    async_reset();
    step(1'b1, 6'h2A, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);

    // Randomised traffic with phases biased toward filling or draining
    phase_wr = 50;
    phase_rd = 50;
    for (int i = 0; i < 600; i++) begin
      if (i % 40 == 0) begin
        phase_wr = $urandom_range(10, 90);
        phase_rd = 100 - phase_wr;
      end
      if ($urandom_range(0, 299) == 0) begin
        async_reset();
      end else begin
        step($urandom_range(0, 99) < phase_wr, DW'($urandom),
             $urandom_range(0, 99) < phase_rd, $urandom_range(0, 7) == 0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/sync_fifo_flags.md
Name: sync_fifo_flags

Overview:
Single-clock, parametrised FIFO. It is the same-clock successor to the team's dual-clock FIFO, for paths where producer and consumer share a clock.
- No synchronizer stages, so FULL and EMPTY carry no 2-cycle penalty.
- Adds an occupancy count, programmable ALMOST_FULL/ALMOST_EMPTY thresholds, sticky overflow/underflow error flags, and a selectable first-word-fall-through (FWFT) read mode.
- Sits between a streaming producer and consumer inside one clock domain.

Parameters:
DEPTH, 8, number of entries; must be a power of 2 and ≥2 (elaboration error otherwise).
DATA_WIDTH, 6, word width in bits.
FWFT, 0, 0 = standard read (1-cycle latency); 1 = first-word-fall-through.
AF_THRESH, 6, ALMOST_FULL asserts when count ≥ AF_THRESH; legal range 1..DEPTH.
AE_THRESH, 2, ALMOST_EMPTY asserts when count ≤ AE_THRESH; legal range 0..DEPTH-1, and must be < AF_THRESH.

Ports:
clk  in  1  single clock, rising edge.
rst_n  in  1  asynchronous, active-low reset.
wr_en  in  1  write request.
data_in  in  DATA_WIDTH  write data.
rd_en  in  1  read request (standard mode) / pop acknowledge (FWFT mode).
clr_err  in  1  synchronous clear of the sticky error flags.
data_out  out  DATA_WIDTH  read data.
FULL  out  1  count == DEPTH.
EMPTY  out  1  count == 0.
ALMOST_FULL  out  1  count ≥ AF_THRESH.
ALMOST_EMPTY  out  1  count ≤ AE_THRESH.
count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
overflow  out  1  sticky: a write was attempted while FULL.
underflow  out  1  sticky: a read was attempted while EMPTY.
wr_ptr, rd_ptr  out  $clog2(DEPTH)+1  binary pointers, exposed for debug.

Behaviour:
Reset
- Asynchronous assertion clears wr_ptr, rd_ptr, data_out, overflow and underflow to 0.
- Resulting flag values: EMPTY=1, FULL=0, ALMOST_EMPTY=1, ALMOST_FULL=0, count=0.
- Storage array is not reset. Reset mid-operation discards all contents; release is synchronous to clk.

Pointers
- Width ptr_bits+1. Low bits address storage; the MSB is the wrap bit.
- Each pointer increments modulo 2^(ptr_bits+1).
- count = wr_ptr − rd_ptr, computed modulo 2^(ptr_bits+1).
- FULL when the MSBs differ and the low bits are equal; EMPTY when the pointers are equal.
- All flags and count decode combinationally from registered pointers and update the cycle after the causing edge.

Write
- Accepted when wr_en && !FULL, with FULL sampled before the edge.
- On acceptance: mem[wr_ptr] <= data_in and wr_ptr increments.

Read, FWFT=0
- Accepted when rd_en && !EMPTY.
- On acceptance: data_out <= mem[rd_ptr] at that edge (1-cycle latency) and rd_ptr increments.
- Otherwise data_out holds its value.

Read, FWFT=1
- data_out = mem[rd_ptr] combinationally when !EMPTY, and 0 when EMPTY.
- rd_en && !EMPTY pops the word: rd_ptr increments and the next word appears in the following cycle.
- A word written into an empty FIFO is visible on data_out the cycle after the write edge.

Simultaneous read and write
- Neither FULL nor EMPTY: both accepted, count unchanged.
- FULL: the read is accepted; the write is rejected and sets overflow; count becomes DEPTH-1.
- EMPTY: the write is accepted; the read is rejected and sets underflow; count becomes 1.

Error flags
- overflow is set by wr_en && FULL; underflow is set by rd_en && EMPTY.
- Both are cleared by clr_err. Set has priority over clear in the same cycle.
- Rejected operations never modify pointers or storage.

Decomposition:
- Shared package/header holds ptr_bits = $clog2(DEPTH) and the parameter legality checks (power-of-2 DEPTH; AE_THRESH < AF_THRESH ≤ DEPTH).
- One sub-module, fifo_flag_gen: takes wr_ptr/rd_ptr and the thresholds, produces count, FULL, EMPTY, ALMOST_FULL and ALMOST_EMPTY.
- Storage, pointer registers, read-mode mux and error flags live in the top level.

Test Plan:
1. Reset/fill (DEPTH=8, FWFT=0): assert rst_n=0 → EMPTY=1, count=0, data_out=0. Write 0x01..0x08 on 8 consecutive cycles → ALMOST_FULL rises when count=6; FULL=1 and count=8 after the 8th edge.
2. Overflow/clear: while FULL, write 0x3F → overflow=1, count stays 8, no data change. Pulse clr_err → overflow=0. Pulse clr_err together with wr_en while FULL → overflow stays 1.
3. Drain, standard mode: read 8 times → data_out sequence 0x01..0x08, each valid 1 cycle after its rd_en edge; ALMOST_EMPTY when count≤2; EMPTY after the 8th read. A 9th read sets underflow=1 and data_out holds 0x08.
4. Wrap-around: run 20 write/read pairs with an offset of 3 entries → pointers wrap past 15→0, count stays 3, data order is preserved, FULL/EMPTY are never asserted falsely.
5. Simultaneous operations: at count=8 with wr_en=rd_en=1 → count=7, overflow=1. At count=0 with both asserted → count=1, underflow=1, and the written word is read back next.
6. FWFT=1: write 0x2A into an empty FIFO → data_out=0x2A the next cycle with no rd_en. Pop → data_out=0 and EMPTY=1. Assert rst_n=0 mid-stream at count=5 → count=0 immediately and data_out=0.
